// File: rtl/heap_cmd_dispatch.sv
// heap_cmd_dispatch: queues core heap commands and issues them one at a time to a heap unit
module heap_cmd_dispatch #(
  parameter int HEAP_SIZE     = 25,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 7,
  parameter int POP_TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_v,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_tag,
  output logic        h_v,
  output logic [4:0]  h_rd,
  output logic [31:0] h_data,
  input  logic        h_out_v,
  input  logic [31:0] h_out_data,
  output logic        wb_v,
  output logic [4:0]  wb_tag,
  output logic [31:0] wb_data,
  output logic        wb_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(HEAP_SIZE + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_POP, SETTLE, RESP} state_t;
  state_t state, next;
  logic [38:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic full, empty, enq, deq, legal;
  logic [38:0] head;
  logic [1:0] cmd_op;
  logic [31:0] cmd_data, pop_data;
  logic [4:0] cmd_tag;
  logic err;
  logic [CW-1:0] cnt;
  logic [15:0] tmr;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign in_ready = ~full;
  assign enq = in_v & ~full;
  assign head = mem[rp[AW-1:0]];
  assign legal = (head[38:37] == 2'd0 && cnt < CW'(HEAP_SIZE)) || (head[38:37] == 2'd1 && cnt != '0);
  // command queue; memory contents need no reset since the pointers gate them
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (enq) begin
        mem[wp[AW-1:0]] <= {in_op, in_data, in_tag};
        wp <= wp + 1'b1;
      end
      if (deq) rp <= rp + 1'b1;
    end
  end
  // next-state decode and heap command drive; heap sees a no-op outside ISSUE
  always_comb begin
    next = state;
    deq = 1'b0;
    h_v = 1'b0;
    h_rd = 5'd31;
    h_data = '0;
    case (state)
      IDLE: if (!empty) begin
        deq = 1'b1;
        next = legal ? ISSUE : RESP;
      end
      ISSUE: begin
        h_v = 1'b1;
        h_rd = {4'b0, cmd_op[0]};
        h_data = cmd_op[0] ? '0 : cmd_data;
        next = cmd_op[0] ? WAIT_POP : SETTLE;
      end
      WAIT_POP: next = h_out_v ? SETTLE : (tmr == 16'(POP_TIMEOUT - 1) ? RESP : WAIT_POP);
      SETTLE: next = tmr == 16'(SETTLE_CYCLES - 1) ? RESP : SETTLE;
      RESP: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // state, shadow occupancy count, command register and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      err <= 1'b0;
      cmd_op <= '0;
      cmd_data <= '0;
      cmd_tag <= '0;
      pop_data <= '0;
      wb_v <= 1'b0;
      wb_tag <= '0;
      wb_data <= '0;
      wb_err <= 1'b0;
    end else begin
      state <= next;
      tmr <= (next == state) ? tmr + 1'b1 : '0;
      wb_v <= state == RESP;
      if (deq) begin
        {cmd_op, cmd_data, cmd_tag} <= head;
        err <= !legal && head[38:37] != 2'd2;
      end
      if (state == ISSUE) cnt <= cmd_op[0] ? cnt - 1'b1 : cnt + 1'b1;
      if (state == WAIT_POP && h_out_v) pop_data <= h_out_data;
      if (state == WAIT_POP && !h_out_v && next == RESP) err <= 1'b1;
      if (state == RESP) begin
        wb_tag <= cmd_tag;
        wb_err <= err;
        wb_data <= err ? '0 : (cmd_op == 2'd1 ? pop_data : 32'(cnt));
      end
    end
  end
endmodule
